// File: rtl/pong_game_ctrl_pkg.sv
// Shared types and constants for the pong game sequencer.
package pong_game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam logic [1:0] TXT_NONE = 2'b00;
  localparam logic [1:0] TXT_RULE = 2'b01;
  localparam logic [1:0] TXT_OVER = 2'b10;

  localparam int unsigned TIMER_W = 7;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned LIVES_W = 2;

endpackage

// File: rtl/pong_game_ctrl_bcd_score_cnt.sv
// Two-digit BCD score counter with synchronous clear and saturating increment.
module bcd_score_cnt
  import pong_game_ctrl_pkg::*;
#(
  parameter int unsigned SCORE_MAX = 99
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clr,
  input  logic               i_inc,
  output logic [DIGIT_W-1:0] o_d1,
  output logic [DIGIT_W-1:0] o_d0
);

  localparam logic [DIGIT_W-1:0] MAX_D1 = DIGIT_W'(SCORE_MAX / 10);
  localparam logic [DIGIT_W-1:0] MAX_D0 = DIGIT_W'(SCORE_MAX % 10);

  logic [DIGIT_W-1:0] r_d1;
  logic [DIGIT_W-1:0] r_d0;
  logic               w_at_max;

  assign w_at_max = (r_d1 == MAX_D1) && (r_d0 == MAX_D0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d1 <= '0;
      r_d0 <= '0;
    end else if (i_clr) begin
      r_d1 <= '0;
      r_d0 <= '0;
    end else if (i_inc && !w_at_max) begin
      if (r_d0 == DIGIT_W'(9)) begin
        r_d0 <= '0;
        r_d1 <= r_d1 + DIGIT_W'(1);
      end else begin
        r_d0 <= r_d0 + DIGIT_W'(1);
      end
    end
  end

  assign o_d1 = r_d1;
  assign o_d0 = r_d0;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: start-button conditioning, game FSM, lives and score tracking.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int unsigned LIVES     = 3,
  parameter int unsigned SCORE_MAX = 99
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_start,
  input  logic               hit,
  input  logic               miss,
  input  logic               timer_up,
  output logic               timer_start,
  output logic               graph_still,
  output logic [1:0]         text_sel,
  output logic [DIGIT_W-1:0] score_d1,
  output logic [DIGIT_W-1:0] score_d0,
  output logic [LIVES_W-1:0] lives
);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  state_t             r_state;
  logic               r_sync0;
  logic               r_sync1;
  logic               r_sync_d;
  logic [LIVES_W-1:0] r_lives;
  logic               r_graph_still;
  logic [1:0]         r_text_sel;

  logic w_start_p;
  logic w_play_miss;
  logic w_score_inc;
  logic w_score_clr;

  // Two-flop synchroniser plus rising-edge detect; a held button serves once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync0  <= 1'b0;
      r_sync1  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync0  <= btn_start;
      r_sync1  <= r_sync0;
      r_sync_d <= r_sync1;
    end
  end

  assign w_start_p   = r_sync1 & ~r_sync_d;
  assign w_play_miss = (r_state == ST_PLAY) && miss;
  assign w_score_inc = (r_state == ST_PLAY) && hit && !miss;
  assign w_score_clr = (r_state == ST_OVER) && timer_up;

  // Reload pulse shares the edge with the state change, so the pause always starts fresh.
  assign timer_start = w_play_miss;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_NEWGAME;
      r_lives       <= LIVES_INIT;
      r_graph_still <= 1'b1;
      r_text_sel    <= TXT_RULE;
    end else begin
      case (r_state)
        ST_NEWGAME: begin
          if (w_start_p) begin
            r_state       <= ST_PLAY;
            r_graph_still <= 1'b0;
            r_text_sel    <= TXT_NONE;
          end
        end
        ST_PLAY: begin
          if (miss) begin
            if (r_lives != '0) begin
              r_lives <= r_lives - LIVES_W'(1);
            end
            r_graph_still <= 1'b1;
            if (r_lives <= LIVES_W'(1)) begin
              r_state    <= ST_OVER;
              r_text_sel <= TXT_OVER;
            end else begin
              r_state    <= ST_NEWBALL;
              r_text_sel <= TXT_NONE;
            end
          end
        end
        ST_NEWBALL: begin
          if (timer_up && w_start_p) begin
            r_state       <= ST_PLAY;
            r_graph_still <= 1'b0;
            r_text_sel    <= TXT_NONE;
          end
        end
        ST_OVER: begin
          if (timer_up) begin
            r_state       <= ST_NEWGAME;
            r_lives       <= LIVES_INIT;
            r_graph_still <= 1'b1;
            r_text_sel    <= TXT_RULE;
          end
        end
        default: begin
          r_state       <= ST_NEWGAME;
          r_lives       <= LIVES_INIT;
          r_graph_still <= 1'b1;
          r_text_sel    <= TXT_RULE;
        end
      endcase
    end
  end

  bcd_score_cnt #(
    .SCORE_MAX(SCORE_MAX)
  ) u_score (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_score_clr),
    .i_inc (w_score_inc),
    .o_d1  (score_d1),
    .o_d0  (score_d0)
  );

  assign graph_still = r_graph_still;
  assign text_sel    = r_text_sel;
  assign lives       = r_lives;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: vector table, directed corner sequences, random play.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start;
  logic       hit;
  logic       miss;
  logic       timer_up;
  logic       timer_start;
  logic       graph_still;
  logic [1:0] text_sel;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [1:0] lives;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.LIVES(3), .SCORE_MAX(99)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_start   (btn_start),
    .hit         (hit),
    .miss        (miss),
    .timer_up    (timer_up),
    .timer_start (timer_start),
    .graph_still (graph_still),
    .text_sel    (text_sel),
    .score_d1    (score_d1),
    .score_d0    (score_d0),
    .lives       (lives)
  );

  // Reference model: game phase, score as an integer, button history sampled per edge.
  typedef enum {M_IDLE, M_RALLY, M_SERVE_WAIT, M_END} mode_e;
  mode_e m_mode;
  int    m_score;
  int    m_lives;
  int    m_hist[$];

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_score = 0;
    m_lives = 3;
    m_hist  = {0, 0, 0};
  endtask

  // A serve request is seen three edges after the button rises, once per press.
  function automatic bit model_start();
    return (m_hist[1] == 1) && (m_hist[0] == 0);
  endfunction

  task automatic model_step(input bit b, input bit h, input bit ms, input bit tu);
    bit st;
    st = model_start();
    case (m_mode)
      M_IDLE:       if (st) m_mode = M_RALLY;
      M_RALLY: begin
        if (ms) begin
          m_lives = m_lives - 1;
          m_mode  = (m_lives == 0) ? M_END : M_SERVE_WAIT;
        end else if (h && m_score < 99) begin
          m_score = m_score + 1;
        end
      end
      M_SERVE_WAIT: if (tu && st) m_mode = M_RALLY;
      M_END: if (tu) begin
        m_mode  = M_IDLE;
        m_score = 0;
        m_lives = 3;
      end
      default: m_mode = M_IDLE;
    endcase
    m_hist.push_back(int'(b));
    void'(m_hist.pop_front());
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input bit gs, input logic [1:0] txt, input int score, input int lv);
    chk("graph_still", 8'(graph_still), 8'(gs));
    chk("text_sel", 8'(text_sel), 8'(txt));
    chk("score_d1", 8'(score_d1), 8'(score / 10));
    chk("score_d0", 8'(score_d0), 8'(score % 10));
    chk("lives", 8'(lives), 8'(lv));
  endtask

  task automatic chk_model();
    logic [1:0] txt;
    txt = (m_mode == M_IDLE) ? 2'b01 : (m_mode == M_END) ? 2'b10 : 2'b00;
    chk_outputs(m_mode != M_RALLY, txt, m_score, m_lives);
  endtask

  task automatic drive(input bit b, input bit h, input bit ms, input bit tu);
    @(negedge clk);
    btn_start = b;
    hit       = h;
    miss      = ms;
    timer_up  = tu;
    #1;
  endtask

  // One model-checked clock: combinational reload pulse before the edge, registers after.
  task automatic cyc(input bit b, input bit h, input bit ms, input bit tu);
    drive(b, h, ms, tu);
    chk("timer_start", 8'(timer_start), 8'(m_mode == M_RALLY && ms));
    @(posedge clk);
    model_step(b, h, ms, tu);
    #1;
    chk_model();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; btn_start = 1'b0; hit = 1'b0; miss = 1'b0; timer_up = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_timer_start", 8'(timer_start), 8'd0);
    chk_outputs(1'b1, 2'b01, 0, 3);
  endtask

  task automatic serve();
    repeat (3) cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
  endtask

  typedef struct {
    bit b, h, ms, tu;
    bit ts, gs;
    logic [1:0] txt;
    int score, lv;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit b, h, ms, tu, ts, gs, input logic [1:0] txt, input int sc, lv);
    vec_t v;
    v.b = b; v.h = h; v.ms = ms; v.tu = tu; v.ts = ts; v.gs = gs;
    v.txt = txt; v.score = sc; v.lv = lv;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rb;
    reset = 1'b1; btn_start = 1'b0; hit = 1'b0; miss = 1'b0; timer_up = 1'b0;

    //   b  h  m  t  ts gs txt sc lv
    add(1, 0, 0, 0, 0, 1, 1, 0, 3);
    add(1, 1, 0, 0, 0, 1, 1, 0, 3);
    add(1, 0, 0, 0, 0, 0, 0, 0, 3);
    add(1, 1, 0, 0, 0, 0, 0, 1, 3);
    add(1, 1, 0, 0, 0, 0, 0, 2, 3);
    add(1, 0, 0, 0, 0, 0, 0, 2, 3);
    add(1, 1, 1, 0, 1, 1, 0, 2, 2);
    add(0, 0, 0, 0, 0, 1, 0, 2, 2);
    add(0, 0, 0, 0, 0, 1, 0, 2, 2);
    add(1, 0, 0, 0, 0, 1, 0, 2, 2);
    add(1, 0, 0, 0, 0, 1, 0, 2, 2);
    add(1, 0, 0, 0, 0, 1, 0, 2, 2);
    add(1, 0, 0, 1, 0, 1, 0, 2, 2);
    add(0, 1, 1, 1, 0, 1, 0, 2, 2);
    add(0, 0, 0, 1, 0, 1, 0, 2, 2);
    add(1, 0, 0, 1, 0, 1, 0, 2, 2);
    add(1, 0, 0, 1, 0, 1, 0, 2, 2);
    add(1, 0, 0, 1, 0, 0, 0, 2, 2);
    add(0, 0, 1, 0, 1, 1, 0, 2, 1);
    add(0, 0, 0, 1, 0, 1, 0, 2, 1);

    apply_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].b, tbl[i].h, tbl[i].ms, tbl[i].tu);
      chk($sformatf("vec%0d_timer_start", i), 8'(timer_start), 8'(tbl[i].ts));
      @(posedge clk);
      model_step(tbl[i].b, tbl[i].h, tbl[i].ms, tbl[i].tu);
      #1;
      chk_outputs(tbl[i].gs, tbl[i].txt, tbl[i].score, tbl[i].lv);
    end

    // Last ball: serve, miss into OVER, wait out the pause, back to a fresh game.
    serve();
    cyc(0, 0, 1, 0);
    chk("over_lives", 8'(lives), 8'd0);
    chk("over_text", 8'(text_sel), 8'd2);
    repeat (3) cyc(1, 1, 1, 0);
    cyc(0, 0, 0, 1);
    chk_outputs(1'b1, 2'b01, 0, 3);

    // Saturation at 99.
    apply_reset();
    serve();
    repeat (101) cyc(0, 1, 0, 0);
    chk("sat_d1", 8'(score_d1), 8'd9);
    chk("sat_d0", 8'(score_d0), 8'd9);

    // Asynchronous reset during a miss cycle at score 45.
    apply_reset();
    serve();
    repeat (45) cyc(0, 1, 0, 0);
    @(negedge clk);
    hit = 1'b1; miss = 1'b1;
    #1;
    chk("pre_rst_timer_start", 8'(timer_start), 8'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_timer_start", 8'(timer_start), 8'd0);
    chk_outputs(1'b1, 2'b01, 0, 3);
    @(negedge clk);
    reset = 1'b0; hit = 1'b0; miss = 1'b0;
    model_reset();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 1);

    // Random play against the model.
    rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) rb = ~rb;
      cyc(rb, $urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
